// File: rtl/spi_slave.sv
// SPI mode-0 responder: oversampled pins, MSB-first DATA_WIDTH words, valid-pulse rx, one-entry tx holding register.
// Build option: define SPI_SLAVE_FRAME_ERR_EN to pulse frame_err when cs_n or enable cuts a word short.
module spi_slave #(
   parameter int unsigned           DATA_WIDTH   = 16,
   parameter int unsigned           SYNC_STAGES  = 2,
   parameter logic [DATA_WIDTH-1:0] IDLE_TX_WORD = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  sclk,
   input  logic                  cs_n,
   input  logic                  mosi,
   output logic                  miso,
   output logic                  miso_oe,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic                  tx_underrun,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  frame_err,
   output logic                  busy
);

   localparam int unsigned          CNT_W      = $clog2(DATA_WIDTH + 1);
   localparam logic [CNT_W-1:0]     LAST_BIT   = CNT_W'(DATA_WIDTH - 1);
   localparam logic [2:0]           FLUSH_DONE = 3'(SYNC_STAGES + 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // ---------------------------------------------------------------
   // Pin synchronizers and edge detection
   // ---------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sclk_sr;
   logic [SYNC_STAGES-1:0] cs_sr;
   logic [SYNC_STAGES-1:0] mosi_sr;
   logic                   sclk_prev;
   logic                   cs_prev;
   logic                   sclk_s;
   logic                   cs_s;
   logic                   mosi_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sr   <= '0;
         cs_sr     <= '1;
         mosi_sr   <= '0;
         sclk_prev <= 1'b0;
         cs_prev   <= 1'b1;
      end else begin
         sclk_sr   <= {sclk_sr[SYNC_STAGES-2:0], sclk};
         cs_sr     <= {cs_sr[SYNC_STAGES-2:0], cs_n};
         mosi_sr   <= {mosi_sr[SYNC_STAGES-2:0], mosi};
         sclk_prev <= sclk_s;
         cs_prev   <= cs_s;
      end
   end

   assign sclk_s = sclk_sr[SYNC_STAGES-1];
   assign cs_s   = cs_sr[SYNC_STAGES-1];
   assign mosi_s = mosi_sr[SYNC_STAGES-1];

   // A cs_n already low when reset releases flows through the chain as a fake
   // falling edge; frames are only armed once cs_n has been seen high after the flush.
   logic [2:0] flush_cnt;
   logic       cs_armed;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flush_cnt <= '0;
         cs_armed  <= 1'b0;
      end else if (flush_cnt != FLUSH_DONE) begin
         flush_cnt <= flush_cnt + 1'b1;
      end else if (cs_s) begin
         cs_armed  <= 1'b1;
      end
   end

   logic sclk_rise;
   logic sclk_fall;
   logic cs_fall;
   logic cs_rise;

   assign sclk_rise = sclk_s & ~sclk_prev;
   assign sclk_fall = ~sclk_s & sclk_prev;
   assign cs_fall   = ~cs_s & cs_prev & cs_armed;
   assign cs_rise   = cs_s & ~cs_prev;

   // ---------------------------------------------------------------
   // Transmit holding register
   // ---------------------------------------------------------------
   state_t                  state;
   logic [CNT_W-1:0]        bit_cnt;
   logic                    boundary;
   logic [DATA_WIDTH-1:0]   tx_shift;
   logic [DATA_WIDTH-1:0]   rx_shift;
   logic                    word_done;
   logic                    hold_full;
   logic [DATA_WIDTH-1:0]   hold_data;
   logic                    load_now;
   logic                    word_end;
   logic                    tx_accept;
   logic [DATA_WIDTH-1:0]   load_word;

   // cs_rise outranks a simultaneous sclk_fall, so a master that releases cs_n on
   // the closing SCLK fall does not trigger a spurious next-word load.
   assign load_now  = enable &&
                      (((state == IDLE) && cs_fall) ||
                       ((state == SHIFT) && sclk_fall && boundary && !cs_rise));
   assign word_end  = sclk_rise && (bit_cnt == LAST_BIT);
   assign load_word = hold_full ? hold_data : IDLE_TX_WORD;

   // Handshake: a transfer happens when tx_valid is high and either tx_ready is
   // high or a word load empties the register in that same cycle; in the latter
   // case the load takes the old word and the register stays full.
   assign tx_accept = tx_valid && (!hold_full || load_now);
   assign tx_ready  = !hold_full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_full <= 1'b0;
         hold_data <= '0;
      end else if (tx_accept) begin
         hold_full <= 1'b1;
         hold_data <= tx_data;
      end else if (load_now) begin
         hold_full <= 1'b0;
      end
   end

   // ---------------------------------------------------------------
   // Frame state machine
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         boundary    <= 1'b0;
         tx_shift    <= '0;
         rx_shift    <= '0;
         rx_data     <= '0;
         word_done   <= 1'b0;
         rx_valid    <= 1'b0;
         tx_underrun <= 1'b0;
         miso        <= 1'b0;
         miso_oe     <= 1'b0;
      end else begin
         word_done   <= 1'b0;
         rx_valid    <= word_done;
         tx_underrun <= load_now && !hold_full;
         miso        <= (state == SHIFT) ? tx_shift[DATA_WIDTH-1] : 1'b0;

         if (!enable) begin
            state    <= IDLE;
            miso_oe  <= 1'b0;
            bit_cnt  <= '0;
            boundary <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  bit_cnt  <= '0;
                  boundary <= 1'b0;
                  if (cs_fall) begin
                     tx_shift <= load_word;
                     miso_oe  <= 1'b1;
                     state    <= SHIFT;
                  end
               end
               SHIFT: begin
                  if (sclk_rise) begin
                     rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
                     if (word_end) begin
                        rx_data   <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
                        word_done <= 1'b1;
                        bit_cnt   <= '0;
                        boundary  <= 1'b1;
                     end else begin
                        bit_cnt   <= bit_cnt + 1'b1;
                     end
                  end
                  // A word completing on the same cycle as cs_rise is kept above.
                  if (cs_rise) begin
                     state    <= IDLE;
                     miso_oe  <= 1'b0;
                     bit_cnt  <= '0;
                     boundary <= 1'b0;
                  end else if (sclk_fall) begin
                     if (boundary) begin
                        tx_shift <= load_word;
                        boundary <= 1'b0;
                     end else begin
                        tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign busy = (state != IDLE);

   // ---------------------------------------------------------------
   // Partial-word detection
   // ---------------------------------------------------------------
`ifdef SPI_SLAVE_FRAME_ERR_EN
   logic abort_partial;

   assign abort_partial = (state == SHIFT) && (bit_cnt != '0) &&
                          (!enable || (cs_rise && !word_end));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_err <= 1'b0;
      end else begin
         frame_err <= abort_partial;
      end
   end
`else
   assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: directed scenarios plus random words, checked against a word-level model of the
// holding register and the master's view of both data streams.
module tb_spi_slave;

   localparam int          W      = 16;
   localparam int          SYNC   = 2;
   localparam int          HP     = 8;
   localparam logic [W-1:0] IDLE_W = 16'h0000;
`ifdef SPI_SLAVE_FRAME_ERR_EN
   localparam int          FERR_ON = 1;
`else
   localparam int          FERR_ON = 0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         enable = 1'b0;
   logic         sclk = 1'b0;
   logic         cs_n = 1'b1;
   logic         mosi = 1'b0;
   logic         tx_valid = 1'b0;
   logic [W-1:0] tx_data = '0;
   logic         miso;
   logic         miso_oe;
   logic         tx_ready;
   logic         tx_underrun;
   logic [W-1:0] rx_data;
   logic         rx_valid;
   logic         frame_err;
   logic         busy;

   spi_slave #(
      .DATA_WIDTH   (W),
      .SYNC_STAGES  (SYNC),
      .IDLE_TX_WORD (IDLE_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .sclk        (sclk),
      .cs_n        (cs_n),
      .mosi        (mosi),
      .miso        (miso),
      .miso_oe     (miso_oe),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .tx_underrun (tx_underrun),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .frame_err   (frame_err),
      .busy        (busy)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------- scoreboard ----------------
   int checks = 0;
   int passed = 0;
   int fails  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   logic [W-1:0] exp_q[$];
   int rx_cnt   = 0;
   int und_cnt  = 0;
   int ferr_cnt = 0;
   int rise_cyc = 0;

   always @(negedge clk) begin
      if (rx_valid) begin
         rx_cnt++;
         check("rx_pending", 32'(exp_q.size() > 0), 32'd1);
         check("rx_latency", 32'(cyc - rise_cyc), 32'(SYNC + 2));
         if (exp_q.size() > 0) check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
      end
      if (tx_underrun) und_cnt++;
      if (frame_err) ferr_cnt++;
   end

   // ---------------- reference model ----------------
   logic         hold_full_m = 1'b0;
   logic [W-1:0] hold_m = '0;
   int           exp_und  = 0;
   int           exp_ferr = 0;

   // Word the slave shifts out at the next word start.
   function automatic logic [W-1:0] model_load();
      if (hold_full_m) begin
         hold_full_m = 1'b0;
         return hold_m;
      end
      exp_und++;
      return IDLE_W;
   endfunction

   // ---------------- drivers ----------------
   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic tx_write(input logic [W-1:0] d);
      int n = 0;
      while (!tx_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("tx_ready_wait", 32'(tx_ready), 32'd1);
      tx_valid = 1'b1;
      tx_data  = d;
      @(negedge clk);
      tx_valid = 1'b0;
      hold_full_m = 1'b1;
      hold_m      = d;
   endtask

   // Mode-0 master: data set on falling edges, sampled on rising edges;
   // cs_n releases together with the final SCLK fall.
   task automatic run_frame(input int nbits, input logic [W-1:0] w0, input logic [W-1:0] w1,
                            input bit expect_rx, output logic [W-1:0] g0, output logic [W-1:0] g1);
      logic [W-1:0] w;
      logic [W-1:0] sr;
      g0 = '0;
      g1 = '0;
      sr = '0;
      @(negedge clk);
      cs_n = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         w    = (i < W) ? w0 : w1;
         mosi = w[W-1-(i%W)];
         wait_clk(HP);
         sclk = 1'b1;
         sr   = {sr[W-2:0], miso};
         if (i % W == W-1) begin
            rise_cyc = cyc;
            if (expect_rx) exp_q.push_back(w);
            if (i < W) g0 = sr;
            else       g1 = sr;
         end
         wait_clk(HP);
         sclk = 1'b0;
         if (i == nbits-1) cs_n = 1'b1;
      end
      mosi = 1'b0;
      wait_clk(4*HP);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_miso"},     32'(miso),        32'd0);
      check({tag, "_miso_oe"},  32'(miso_oe),     32'd0);
      check({tag, "_tx_ready"}, 32'(tx_ready),    32'd1);
      check({tag, "_underrun"}, 32'(tx_underrun), 32'd0);
      check({tag, "_rx_data"},  32'(rx_data),     32'd0);
      check({tag, "_rx_valid"}, 32'(rx_valid),    32'd0);
      check({tag, "_frame_err"},32'(frame_err),   32'd0);
      check({tag, "_busy"},     32'(busy),        32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [W-1:0] g0, g1, exp0, exp1, wa, wb, last_rx;
      int           rx_base, start;

      // Reset state
      wait_clk(3);
      check_reset_values("reset");
      rst_n  = 1'b1;
      enable = 1'b1;
      wait_clk(8);

      // Single word
      tx_write(16'h1234);
      exp0 = model_load();
      run_frame(16, 16'hA5C3, '0, 1'b1, g0, g1);
      check("single_miso_word", 32'(g0), 32'(exp0));
      check("single_rx_data",   32'(rx_data), 32'hA5C3);
      check("single_rx_count",  32'(rx_cnt), 32'd1);
      check("single_tx_ready",  32'(tx_ready), 32'd1);
      check("single_underrun",  32'(und_cnt), 32'(exp_und));

      // Back-to-back words, holding register refilled during the first word
      tx_write(16'($urandom));
      exp0 = model_load();
      fork
         run_frame(32, 16'h0001, 16'hFFFF, 1'b1, g0, g1);
         begin
            wait_clk(21);
            tx_write(16'hBEEF);
         end
      join
      exp1 = model_load();
      check("b2b_miso_word0", 32'(g0), 32'(exp0));
      check("b2b_miso_word1", 32'(g1), 32'(exp1));
      check("b2b_rx_count",   32'(rx_cnt), 32'd3);
      check("b2b_rx_data",    32'(rx_data), 32'hFFFF);
      check("b2b_underrun",   32'(und_cnt), 32'(exp_und));

      // Underrun
      wa   = 16'($urandom);
      exp0 = model_load();
      run_frame(16, wa, '0, 1'b1, g0, g1);
      check("underrun_miso_word", 32'(g0), 32'(exp0));
      check("underrun_count",     32'(und_cnt), 32'(exp_und));
      check("underrun_rx_data",   32'(rx_data), 32'(wa));
      last_rx = wa;

      // Partial frame: 9 bits then cs_n release
      rx_base = rx_cnt;
      exp0 = model_load();
      run_frame(9, 16'($urandom), '0, 1'b0, g0, g1);
      exp_ferr += FERR_ON;
      check("partial_no_rx_valid", 32'(rx_cnt), 32'(rx_base));
      check("partial_rx_data",     32'(rx_data), 32'(last_rx));
      check("partial_frame_err",   32'(ferr_cnt), 32'(exp_ferr));
      check("partial_underrun",    32'(und_cnt), 32'(exp_und));
      wa = 16'($urandom);
      wb = 16'($urandom);
      tx_write(wa);
      exp0 = model_load();
      run_frame(16, wb, '0, 1'b1, g0, g1);
      check("after_partial_miso", 32'(g0), 32'(exp0));
      check("after_partial_rx",   32'(rx_data), 32'(wb));

      // Handshake corner: tx_valid held high across the word load
      wa = 16'($urandom);
      wb = 16'($urandom);
      tx_write(wa);
      tx_valid = 1'b1;
      tx_data  = wb;
      exp0 = model_load();
      fork
         run_frame(16, 16'($urandom), '0, 1'b1, g0, g1);
         begin
            wait_clk(14);
            tx_valid = 1'b0;
            check("corner_tx_ready_mid", 32'(tx_ready), 32'd0);
         end
      join
      hold_full_m = 1'b1;
      hold_m      = wb;
      check("corner_old_word", 32'(g0), 32'(exp0));
      check("corner_tx_ready", 32'(tx_ready), 32'd0);
      exp0 = model_load();
      run_frame(16, 16'($urandom), '0, 1'b1, g0, g1);
      check("corner_new_word",  32'(g0), 32'(exp0));
      check("corner_tx_ready2", 32'(tx_ready), 32'd1);

      // enable dropped mid-word; holding register must survive
      tx_write(16'($urandom));
      exp0 = model_load();
      rx_base = rx_cnt;
      wa = 16'($urandom);
      fork
         run_frame(16, 16'($urandom), '0, 1'b0, g0, g1);
         begin
            start = cyc;
            wait_clk(30);
            tx_write(wa);
            while (cyc - start < 92) @(negedge clk);
            enable = 1'b0;
            wait_clk(2);
            check("enable_busy",    32'(busy), 32'd0);
            check("enable_miso_oe", 32'(miso_oe), 32'd0);
            wait_clk(20);
            enable = 1'b1;
            wait_clk(40);
            check("enable_no_reentry", 32'(busy), 32'd0);
         end
      join
      exp_ferr += FERR_ON;
      check("enable_no_rx_valid", 32'(rx_cnt), 32'(rx_base));
      check("enable_hold_kept",   32'(tx_ready), 32'd0);
      check("enable_frame_err",   32'(ferr_cnt), 32'(exp_ferr));
      wb   = 16'($urandom);
      exp0 = model_load();
      run_frame(16, wb, '0, 1'b1, g0, g1);
      check("enable_next_miso", 32'(g0), 32'(exp0));
      check("enable_next_rx",   32'(rx_data), 32'(wb));

      // Reset mid-frame with cs_n held low through release
      tx_write(16'($urandom));
      exp0 = model_load();
      rx_base = rx_cnt;
      fork
         run_frame(16, 16'($urandom), '0, 1'b0, g0, g1);
         begin
            wait_clk(93);
            rst_n = 1'b0;
            #1;
            check_reset_values("midreset");
            wait_clk(3);
            rst_n = 1'b1;
            wait_clk(60);
            check("midreset_no_start", 32'(busy), 32'd0);
         end
      join
      hold_full_m = 1'b0;
      check("midreset_no_rx_valid", 32'(rx_cnt), 32'(rx_base));
      check("midreset_underrun",    32'(und_cnt), 32'(exp_und));
      exp0 = model_load();
      run_frame(16, 16'h5A5A, '0, 1'b1, g0, g1);
      check("post_reset_rx",   32'(rx_data), 32'h5A5A);
      check("post_reset_miso", 32'(g0), 32'(exp0));

      // Random words, holding register randomly preloaded
      for (int k = 0; k < 6; k++) begin
         if ($urandom_range(0, 1) == 1) tx_write(16'($urandom));
         wa   = 16'($urandom);
         exp0 = model_load();
         run_frame(16, wa, '0, 1'b1, g0, g1);
         check("rand_miso", 32'(g0), 32'(exp0));
         check("rand_rx",   32'(rx_data), 32'(wa));
      end

      wait_clk(10);
      check("final_rx_drained", 32'(exp_q.size()), 32'd0);
      check("final_underrun",   32'(und_cnt), 32'(exp_und));
      check("final_frame_err",  32'(ferr_cnt), 32'(exp_ferr));

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
